fdt_tx_scheduler: RTL and testbench

- Sequences the PICC transmit path against the ISO/IEC 14443-2A frame delay time (FDT).
- Sits between the application bit stream and the tx module's tx_interface (BY_BYTE=0, bit-serial).
- Holds the response off until the FDT grid point after the last received PCD frame, then passes the stream through to the end of the frame.
- If the response is late, slips to the next 128-cycle grid slot; after the last allowed slot, aborts.

---
 rtl/fdt_tx_scheduler.sv | 133 +++++++++++++
 tb/tb_fdt_tx_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fdt_tx_scheduler.sv
// PICC transmit scheduler: holds the bit-serial response until the ISO 14443-2A
// FDT grid point after the last PCD frame, slipping 128-cycle slots up to N_MAX.
module fdt_tx_scheduler #(
  parameter int N_MIN      = 9,
  parameter int N_MAX      = 15,
  parameter int TX_LATENCY = 0,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_eof_i,
  input  logic       rx_last_bit_i,
  input  logic       app_data_i,
  input  logic       app_data_valid_i,
  input  logic       app_last_i,
  output logic       app_req_o,
  output logic       tx_data_o,
  output logic       tx_data_valid_o,
  input  logic       tx_req_i,
  output logic       busy_o,
  output logic [3:0] slot_n_o,
  output logic       tx_done_o,
  output logic       err_late_o,
  output logic       err_underrun_o
);

  typedef enum logic [1:0] {IDLE, WAIT_FDT, STREAM} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target;
  logic [3:0]       slot_q, slot_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             under_q, under_d;
  logic             match;

  assign target = CNT_W'({slot_q, 7'b0}) + (last_q ? CNT_W'(84) : CNT_W'(20))
                  - CNT_W'(TX_LATENCY);
  // cnt_q is 0 one cycle after rx_eof, so the grid cycle is where cnt_q == target-1
  assign match  = (cnt_q == target - CNT_W'(1));

  always_comb begin
    state_d         = state_q;
    cnt_d           = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    slot_d          = slot_q;
    last_d          = last_q;
    done_d          = 1'b0;
    under_d         = 1'b0;
    err_late_o      = 1'b0;
    app_req_o       = 1'b0;
    tx_data_o       = 1'b0;
    tx_data_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_eof_i) begin
          last_d  = rx_last_bit_i;
          slot_d  = 4'(N_MIN);
          cnt_d   = '0;
          state_d = WAIT_FDT;
        end
      end
      WAIT_FDT: begin
        if (match) begin
          tx_data_valid_o = app_data_valid_i;
          tx_data_o       = app_data_i;
          app_req_o       = tx_req_i && app_data_valid_i;
          if (app_data_valid_i) begin
            if (app_req_o && app_last_i) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = STREAM;
            end
          end else if (slot_q < 4'(N_MAX)) begin
            slot_d = slot_q + 4'd1;
          end else begin
            err_late_o = 1'b1;
            state_d    = IDLE;
          end
        end
        if (rx_eof_i) begin
          last_d     = rx_last_bit_i;
          slot_d     = 4'(N_MIN);
          cnt_d      = '0;
          done_d     = 1'b0;
          err_late_o = 1'b0;
          state_d    = WAIT_FDT;
        end
      end
      STREAM: begin
        tx_data_o       = app_data_i;
        tx_data_valid_o = app_data_valid_i;
        app_req_o       = tx_req_i && app_data_valid_i;
        if (!app_data_valid_i) begin
          under_d = 1'b1;
          state_d = IDLE;
        end else if (app_req_o && app_last_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) err_late_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= 4'(N_MIN);
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign slot_n_o       = slot_q;
  assign tx_done_o      = done_q;
  assign err_underrun_o = under_q;

endmodule

// File: tb/tb_fdt_tx_scheduler.sv
// Scoreboard bench for fdt_tx_scheduler: directed scenarios push expected events,
// a negedge monitor pops and compares every transfer, done and error pulse.
module tb_fdt_tx_scheduler;

  logic       clk = 1'b0, rst = 1'b1;
  logic       rx_eof_i = 1'b0, rx_last_bit_i = 1'b0;
  logic       app_data_i = 1'b0, app_data_valid_i = 1'b0, app_last_i = 1'b0;
  logic       tx_req_i = 1'b1;
  logic       app_req_o, tx_data_o, tx_data_valid_o, busy_o;
  logic       tx_done_o, err_late_o, err_underrun_o;
  logic [3:0] slot_n_o;

  int cyc = 0, n_checks = 0, n_fail = 0;

  typedef struct {int kind; int at; logic b;} ev_t;  // kind: 0 xfer, 1 done, 2 late, 3 underrun
  ev_t exp_q[$];

  logic        app_on = 1'b0;
  int          app_start = 0, app_len = 0, app_drop = 99, app_gen = 0;
  logic [15:0] app_pat = '0;
  int          app_ptr = 0, seen_gen = 0;
  logic        adv = 1'b0;

  fdt_tx_scheduler dut (
    .clk(clk), .rst(rst), .rx_eof_i(rx_eof_i), .rx_last_bit_i(rx_last_bit_i),
    .app_data_i(app_data_i), .app_data_valid_i(app_data_valid_i), .app_last_i(app_last_i),
    .app_req_o(app_req_o), .tx_data_o(tx_data_o), .tx_data_valid_o(tx_data_valid_o),
    .tx_req_i(tx_req_i), .busy_o(busy_o), .slot_n_o(slot_n_o), .tx_done_o(tx_done_o),
    .err_late_o(err_late_o), .err_underrun_o(err_underrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Application model: presents pattern bits, advancing on each app_req.
  always @(negedge clk) adv = app_req_o;
  always @(posedge clk) begin
    #1;
    if (seen_gen != app_gen) begin
      seen_gen = app_gen;
      app_ptr  = 0;
    end else if (adv) begin
      app_ptr++;
    end
    app_data_valid_i = app_on && (cyc >= app_start) && (app_ptr < app_len) && (app_ptr != app_drop);
    app_data_i       = app_pat[app_ptr % 16];
    app_last_i       = (app_ptr == app_len - 1);
  end

  task automatic chk_ev(input int k, input logic b);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL ev_unexpected: got kind=%0d cycle=%0d bit=%0b, required no event", k, cyc, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.at != cyc || (k == 0 && e.b !== b)) begin
        n_fail++;
        $display("FAIL ev_match: got kind=%0d cycle=%0d bit=%0b, required kind=%0d cycle=%0d bit=%0b",
                 k, cyc, b, e.kind, e.at, e.b);
      end else begin
        $display("ok   event kind=%0d cycle=%0d bit=%0b", k, cyc, b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tx_data_valid_o && tx_req_i) chk_ev(0, tx_data_o);
    if (tx_done_o)      chk_ev(1, 1'b0);
    if (err_late_o)     chk_ev(2, 1'b0);
    if (err_underrun_o) chk_ev(3, 1'b0);
  end

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", nm, act, cyc);
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic on, input int start, input int len, input int drop, input logic [15:0] pat);
    app_on = on; app_start = start; app_len = len; app_drop = drop; app_pat = pat;
    app_gen++;
  endtask

  task automatic push(input int kind, input int at, input logic b);
    ev_t e;
    e.kind = kind; e.at = at; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic push_bits(input int first, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) push(0, first + i, pat[i]);
  endtask

  task automatic pulse_eof(input logic last, output int e);
    e = cyc;
    rx_last_bit_i = last;
    rx_eof_i = 1'b1;
    @(posedge clk);
    #1;
    rx_eof_i = 1'b0;
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_valid"}, int'(tx_data_valid_o), 0);
    check({nm, "_busy"}, int'(busy_o), 0);
    check({nm, "_pulses"}, int'({tx_done_o, err_late_o, err_underrun_o, app_req_o}), 0);
  endtask

  initial begin
    int e, e2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");
    check("reset_slot", int'(slot_n_o), 9);
    check("reset_txdata", int'(tx_data_o), 0);

    // last=1, 8-bit frame, app ready throughout: grant at 1236
    e = cyc;
    cfg(1'b1, e, 8, 99, 16'h00B2);
    push_bits(e + 1236, 8, 16'h00B2);
    push(1, e + 1244, 1'b0);
    pulse_eof(1'b1, e);
    step_to(e + 100);
    check("wait_busy", int'(busy_o), 1);
    check("wait_slot", int'(slot_n_o), 9);
    step_to(e + 1250);
    check("after_frame_busy", int'(busy_o), 0);

    // last=0, app ready early: grant at 1172
    e = cyc;
    cfg(1'b1, e, 4, 99, 16'h0005);
    push_bits(e + 1172, 4, 16'h0005);
    push(1, e + 1176, 1'b0);
    pulse_eof(1'b0, e);
    step_to(e + 1180);

    // app late by one slot: grant at 1364 in slot 10
    e = cyc;
    cfg(1'b1, e + 1300, 2, 99, 16'h0002);
    push_bits(e + 1364, 2, 16'h0002);
    push(1, e + 1366, 1'b0);
    pulse_eof(1'b1, e);
    step_to(e + 1364);
    check("slip_slot", int'(slot_n_o), 10);
    step_to(e + 1370);

    // app never ready: err_late at 15*128+84
    e = cyc;
    cfg(1'b0, e, 0, 99, 16'h0000);
    push(2, e + 2004, 1'b0);
    pulse_eof(1'b1, e);
    step_to(e + 2003);
    check("late_slot", int'(slot_n_o), 15);
    check("late_busy", int'(busy_o), 1);
    step_to(e + 2006);
    check_quiet("after_late");

    // underrun after 3 transfers, then single-bit frame re-arms
    e = cyc;
    cfg(1'b1, e, 8, 3, 16'h0006);
    push_bits(e + 1236, 3, 16'h0006);
    push(3, e + 1240, 1'b0);
    pulse_eof(1'b1, e);
    step_to(e + 1245);
    check_quiet("after_underrun");
    e2 = cyc;
    cfg(1'b1, e2, 1, 99, 16'h0001);
    push_bits(e2 + 1172, 1, 16'h0001);
    push(1, e2 + 1173, 1'b0);
    pulse_eof(1'b0, e2);
    step_to(e2 + 1176);

    // rx_eof restart at 500 with last=0, then reset mid-stream
    e = cyc;
    cfg(1'b1, e, 8, 99, 16'h005A);
    pulse_eof(1'b1, e);
    step_to(e + 500);
    pulse_eof(1'b0, e2);
    push_bits(e2 + 1172, 3, 16'h005A);
    step_to(e2 + 1174);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("rst_mid_stream");
    rst = 1'b0;
    cfg(1'b0, 0, 0, 99, 16'h0000);
    step_to(cyc + 5);
    check_quiet("after_rst");

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
